// File: rtl/nibble_serial_addsub_sequencer.sv
// Sequencer that performs an 8-bit add or subtract as two nibble passes
// through an external 4-bit carry-lookahead adder stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operation request handshake (op_a, op_b, op_sub)
//   nib_a, nib_b, nib_cin    operands driven to the external adder stage
//   nib_sum, nib_cout        combinational response from the adder stage
//   out_valid / out_ready    result handshake
//   result, carry, zero,
//   negative, overflow       8-bit result and C/Z/N/V flags
//
// state  | meaning
// IDLE   | ready for a new operation
// LOW    | low nibble in the adder stage
// HIGH   | high nibble in the adder stage, flags resolved
// DONE   | result presented, waiting for out_ready

module nibble_serial_addsub_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   input  logic       op_sub,
   output logic [3:0] nib_a,
   output logic [3:0] nib_b,
   output logic       nib_cin,
   input  logic [3:0] nib_sum,
   input  logic       nib_cout,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] result,
   output logic       carry,
   output logic       zero,
   output logic       negative,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] beff_q, beff_d;
   logic       c0_q, c0_d;
   logic       c4_q, c4_d;
   logic [7:0] result_q, result_d;
   logic       carry_q, carry_d;
   logic       zero_q, zero_d;
   logic       negative_q, negative_d;
   logic       overflow_q, overflow_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= 8'h00;
         beff_q     <= 8'h00;
         c0_q       <= 1'b0;
         c4_q       <= 1'b0;
         result_q   <= 8'h00;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         beff_q     <= beff_d;
         c0_q       <= c0_d;
         c4_q       <= c4_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      beff_d     = beff_q;
      c0_d       = c0_q;
      c4_d       = c4_q;
      result_d   = result_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      negative_d = negative_q;
      overflow_d = overflow_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               // Subtract is A + ~B + 1: invert B here, the +1 rides in on c0.
               beff_d  = op_sub ? ~op_b : op_b;
               c0_d    = op_sub;
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            result_d[3:0] = nib_sum;
            c4_d          = nib_cout;
            state_d       = S_HIGH;
         end
         S_HIGH: begin
            result_d[7:4] = nib_sum;
            carry_d       = nib_cout;
            zero_d        = ({nib_sum, result_q[3:0]} == 8'h00);
            negative_d    = nib_sum[3];
            overflow_d    = (a_q[7] == beff_q[7]) && (nib_sum[3] != a_q[7]);
            state_d       = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs depend only on registered state, never on in_valid/out_ready.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      nib_a     = 4'h0;
      nib_b     = 4'h0;
      nib_cin   = 1'b0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_LOW: begin
            nib_a   = a_q[3:0];
            nib_b   = beff_q[3:0];
            nib_cin = c0_q;
         end
         S_HIGH: begin
            nib_a   = a_q[7:4];
            nib_b   = beff_q[7:4];
            nib_cin = c4_q;
         end
         S_DONE: out_valid = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   assign result   = result_q;
   assign carry    = carry_q;
   assign zero     = zero_q;
   assign negative = negative_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_serial_addsub_sequencer.sv
// Scoreboard bench for nibble_serial_addsub_sequencer, paired with a 4-bit
// carry-lookahead adder model.

module tb_nibble_serial_addsub_sequencer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_sub;
   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic       nib_cin;
   logic [3:0] nib_sum;
   logic       nib_cout;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       negative;
   logic       overflow;

   nibble_serial_addsub_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
      .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
      .nib_sum(nib_sum), .nib_cout(nib_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero),
      .negative(negative), .overflow(overflow)
   );

   // 4-bit carry-lookahead adder stage
   logic [3:0] cla_g, cla_p;
   logic [4:0] cla_c;
   assign cla_g    = nib_a & nib_b;
   assign cla_p    = nib_a ^ nib_b;
   assign cla_c[0] = nib_cin;
   assign cla_c[1] = cla_g[0] | (cla_p[0] & cla_c[0]);
   assign cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c[0]);
   assign cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
                   | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
   assign cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
                   | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
                   | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
   assign nib_sum  = cla_p ^ cla_c[3:0];
   assign nib_cout = cla_c[4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] res;
      logic       c, z, n, v;
      int         acc_cyc;
   } exp_t;

   exp_t sb_q[$];

   // Monitor: latency on out_valid rise, stability while held, contents on handshake.
   logic       prev_ov = 1'b0;
   logic [11:0] hold_val = 12'h0;
   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               chk("latency", cyc - sb_q[0].acc_cyc, 32'd3);
            end
            hold_val = {result, carry, zero, negative, overflow};
         end else if (out_valid && prev_ov) begin
            chk("hold_stable", {result, carry, zero, negative, overflow}, hold_val);
         end
         if (out_valid && out_ready && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", result, e.res);
            chk("flags_czvn", {carry, zero, negative, overflow}, {e.c, e.z, e.n, e.v});
         end
         prev_ov = out_valid;
      end
   end

   // Issues one op, checks the nibble traffic, returns at the HIGH-state negedge.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] er, input logic ec, input logic ez,
                        input logic en, input logic ev, output int waited);
      logic [7:0] be;
      logic [4:0] lo;
      exp_t       e;
      be = sub ? ~b : b;
      lo = {1'b0, a[3:0]} + {1'b0, be[3:0]} + {4'b0, sub};
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_sub   = sub;
      waited   = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      chk("idle_nib_zero", {nib_a, nib_b, nib_cin}, 32'd0);
      e.res = er; e.c = ec; e.z = ez; e.n = en; e.v = ev; e.acc_cyc = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      chk("low_nib_a", nib_a, a[3:0]);
      chk("low_nib_b", nib_b, be[3:0]);
      chk("low_nib_cin", nib_cin, sub);
      chk("low_nib_cout", nib_cout, lo[4]);
      chk("low_in_ready", in_ready, 32'd0);
      @(negedge clk);
      chk("high_nib_a", nib_a, a[7:4]);
      chk("high_nib_b", nib_b, be[7:4]);
      chk("high_nib_cin", nib_cin, lo[4]);
   endtask

   initial begin
      int w;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      op_a      = 8'h12;
      op_b      = 8'h34;
      op_sub    = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      chk("rst_in_ready", in_ready, 32'd1);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_result", result, 32'h00);
      chk("rst_flags", {carry, zero, negative, overflow}, 32'd0);
      chk("rst_nib_zero", {nib_a, nib_b, nib_cin}, 32'd0);

      issue(8'h3C, 8'h4A, 1'b0, 8'h86, 1'b0, 1'b0, 1'b1, 1'b1, w);
      issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, w);
      issue(8'h50, 8'h70, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, w);
      issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, w);

      // Backpressure on the 0x80-0x01 result while a new request knocks.
      out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op_a     = 8'h77;
         op_b     = 8'h77;
         op_sub   = 1'b0;
         chk("bp_in_ready", in_ready, 32'd0);
         chk("bp_out_valid", out_valid, 32'd1);
         chk("bp_nib_zero", {nib_a, nib_b, nib_cin}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      issue(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, w);
      chk("accept_after_release", w, 32'd1);
      @(negedge clk);

      // Reset while in HIGH aborts the operation.
      issue(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, w);
      rst = 1'b1;
      void'(sb_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 32'd0);
      chk("abort_in_ready", in_ready, 32'd1);
      chk("abort_result", result, 32'h00);
      chk("abort_flags", {carry, zero, negative, overflow}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 32'd0);
      end

      issue(8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, w);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
